// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bus (imem request/response, redirect, decode handshake); master = fetch unit, slave = environment
interface fetch_if #(
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 32,
  parameter int FQ_DEPTH = 4
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  logic               fetch_en_i;
  logic               imem_req_o;
  logic [PC_W-1:0]    imem_addr_o;
  logic [INSTR_W-1:0] imem_rdata_i;
  logic               redirect_i;
  logic [PC_W-1:0]    redirect_pc_i;
  logic               if_valid_o;
  logic [INSTR_W-1:0] if_instr_o;
  logic [PC_W-1:0]    if_pc_o;
  logic               id_ready_i;
  logic [CW-1:0]      fq_count_o;
  modport master (
    input  fetch_en_i, imem_rdata_i, redirect_i, redirect_pc_i, id_ready_i,
    output imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o, fq_count_o
  );
  modport slave (
    output fetch_en_i, imem_rdata_i, redirect_i, redirect_pc_i, id_ready_i,
    input  imem_req_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o, fq_count_o
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC + 1-cycle imem requests + FIFO fetch queue to decode; ports clk_i, rst_i (sync, high), bus (fetch_if.master)
module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 32,
  parameter int              FQ_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 1
) (
  input logic     clk_i,
  input logic     rst_i,
  fetch_if.master bus
);
  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;
  logic [PC_W-1:0]    pc_r, inflight_pc;
  logic               inflight;
  logic [AW-1:0]      head, tail;
  logic [CW-1:0]      count;
  logic [INSTR_W-1:0] instr_q [FQ_DEPTH];
  logic [PC_W-1:0]    pc_q [FQ_DEPTH];
  logic               valid, issue, push, pop;
  // Credits count the in-flight response so the queue can never overflow;
  // a killed response never pushes because redirect clears the in-flight flag.
  always_comb begin
    valid = count != '0;
    issue = bus.fetch_en_i & ~bus.redirect_i & ~rst_i & ((count + CW'(inflight)) < CW'(FQ_DEPTH));
    push  = inflight & ~bus.redirect_i;
    pop   = valid & bus.id_ready_i & ~bus.redirect_i;
  end
  assign bus.imem_req_o  = issue;
  assign bus.imem_addr_o = issue ? pc_r : '0;
  assign bus.if_valid_o  = valid;
  assign bus.if_instr_o  = valid ? instr_q[head] : '0;
  assign bus.if_pc_o     = valid ? pc_q[head] : '0;
  assign bus.fq_count_o  = count;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_r        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (bus.redirect_i) begin
      pc_r     <= bus.redirect_pc_i;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (issue) pc_r <= pc_r + PC_W'(PC_STEP);
      inflight    <= issue;
      inflight_pc <= pc_r;
      head        <= head + AW'(pop);
      tail        <= tail + AW'(push);
      count       <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push & ~rst_i) begin
      instr_q[tail] <= bus.imem_rdata_i;
      pc_q[tail]    <= inflight_pc;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(push && count == CW'(FQ_DEPTH)));
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a queue-based reference model
module tb_fetch_unit;
  typedef struct packed {logic [7:0] pc; logic [31:0] instr;} ent_t;
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;
  fetch_if #(.PC_W(8), .INSTR_W(32), .FQ_DEPTH(4)) ifa ();
  fetch_if #(.PC_W(8), .INSTR_W(32), .FQ_DEPTH(4)) ifb ();
  fetch_unit #(.PC_W(8), .INSTR_W(32), .FQ_DEPTH(4), .RESET_PC(8'h00), .PC_STEP(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(ifa));
  fetch_unit #(.PC_W(8), .INSTR_W(32), .FQ_DEPTH(4), .RESET_PC(8'hFE), .PC_STEP(1)) dut_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .bus(ifb));
  int vectors = 0;
  int errors  = 0;
  ent_t q[$];
  logic [7:0] m_pc, m_ipc;
  bit m_infl;
  bit prev_req, prev_req_b;
  logic [7:0] prev_addr, prev_addr_b;
  bit en_b, rdy_b;
  logic [52:0] obs_v, exp_v;
  logic o_req, o_valid, ob_valid;
  logic [7:0] o_addr, o_pc, ob_pc;
  logic [31:0] ob_instr;
  logic [2:0] o_cnt;
  task automatic cycle(input bit rst, input bit en, input bit rdy, input bit redir, input logic [7:0] rpc);
    bit hv, e_req;
    ifa.imem_rdata_i  = prev_req ? ~{24'h0, prev_addr} : $urandom;
    ifb.imem_rdata_i  = prev_req_b ? ~{24'h0, prev_addr_b} : $urandom;
    rst_i             = rst;
    ifa.fetch_en_i    = en;
    ifa.id_ready_i    = rdy;
    ifa.redirect_i    = redir;
    ifa.redirect_pc_i = rpc;
    ifb.fetch_en_i    = en_b;
    ifb.id_ready_i    = rdy_b;
    ifb.redirect_i    = 1'b0;
    ifb.redirect_pc_i = 8'h00;
    #1;
    hv    = q.size() != 0;
    e_req = en && !redir && !rst && (q.size() + int'(m_infl) < 4);
    exp_v = {e_req, e_req ? m_pc : 8'h00, hv, hv ? q[0].pc : 8'h00, hv ? q[0].instr : 32'h0, 3'(q.size())};
    obs_v = {ifa.imem_req_o, ifa.imem_addr_o, ifa.if_valid_o, ifa.if_pc_o, ifa.if_instr_o, ifa.fq_count_o};
    {o_req, o_addr, o_valid, o_pc, o_cnt} = {ifa.imem_req_o, ifa.imem_addr_o, ifa.if_valid_o, ifa.if_pc_o, ifa.fq_count_o};
    {ob_valid, ob_pc, ob_instr} = {ifb.if_valid_o, ifb.if_pc_o, ifb.if_instr_o};
    prev_req    = ifa.imem_req_o;
    prev_addr   = ifa.imem_addr_o;
    prev_req_b  = ifb.imem_req_o;
    prev_addr_b = ifb.imem_addr_o;
    if (rst) begin
      q.delete();
      m_pc   = 8'h00;
      m_infl = 0;
    end else if (redir) begin
      q.delete();
      m_pc   = rpc;
      m_infl = 0;
    end else begin
      if (hv && rdy) void'(q.pop_front());
      if (m_infl) q.push_back('{pc: m_ipc, instr: ~{24'h0, m_ipc}});
      m_infl = e_req;
      m_ipc  = m_pc;
      if (e_req) m_pc = m_pc + 8'd1;
    end
    @(posedge clk_i);
    #1;
  endtask
  task automatic test_reset();
    cycle(1, 1, 1, 0, 8'h00);
    cycle(1, 1, 1, 1, 8'h33);
    cycle(0, 0, 0, 0, 8'h00);
    vectors++;
    if (obs_v !== 53'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", obs_v);
    end
    vectors++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL reset_model got %h exp %h", obs_v, exp_v);
    end
  endtask
  task automatic test_first_fetch();
    int first = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, 1, 0, 8'h00);
      if (o_valid && first < 0) first = i;
      vectors++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL first_fetch c%0d got %h exp %h", i, obs_v, exp_v);
      end
    end
    vectors++;
    if (first != 2) begin
      errors++;
      $display("FAIL first_fetch_latency got %0d exp 2", first);
    end
  endtask
  task automatic test_stall();
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 0, 8'h00);
      vectors++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL stall c%0d got %h exp %h", i, obs_v, exp_v);
      end
    end
    vectors++;
    if (o_cnt !== 3'd4 || o_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_full got cnt=%0d req=%b exp cnt=4 req=0", o_cnt, o_req);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 1'($urandom_range(0, 1)), 0, 8'h00);
      vectors++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL stall_release c%0d got %h exp %h", i, obs_v, exp_v);
      end
    end
  endtask
  task automatic fill(input int n, input string name);
    for (int k = 0; k < 12 && (q.size() != 0 || m_infl); k++) begin
      cycle(0, 0, 1, 0, 8'h00);
      vectors++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL %s_drain got %h exp %h", name, obs_v, exp_v);
      end
    end
    for (int k = 0; k < 8 && !(q.size() == n && m_infl); k++) begin
      cycle(0, 1, 0, 0, 8'h00);
      vectors++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL %s_fill got %h exp %h", name, obs_v, exp_v);
      end
    end
    vectors++;
    if (o_cnt !== 3'(n - 1)) begin
      errors++;
      $display("FAIL %s_setup got cnt=%0d exp %0d", name, o_cnt, n - 1);
    end
  endtask
  task automatic test_redirect();
    fill(3, "redirect");
    cycle(0, 1, 0, 1, 8'h40);
    vectors++;
    if (o_req !== 1'b0 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL redirect_R got req=%b valid=%b exp req=0 valid=1", o_req, o_valid);
    end
    for (int i = 1; i <= 5; i++) begin
      cycle(0, 1, 1, 0, 8'h00);
      vectors++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL redirect R+%0d got %h exp %h", i, obs_v, exp_v);
      end
      if (i == 1 && o_valid !== 1'b0) begin
        vectors++;
        errors++;
        $display("FAIL redirect_flush got valid=%b exp 0", o_valid);
      end
      if (i == 3 || i == 4) begin
        vectors++;
        if (o_valid !== 1'b1 || o_pc !== 8'h40 + 8'(i - 3)) begin
          errors++;
          $display("FAIL redirect_target R+%0d got valid=%b pc=%h exp pc=%h", i, o_valid, o_pc, 8'h40 + 8'(i - 3));
        end
      end
    end
  endtask
  task automatic test_redirect_pop();
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 8'h00);
    cycle(0, 1, 1, 1, 8'h80);
    vectors++;
    if (obs_v !== exp_v || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL redirect_pop_R got %h exp %h", obs_v, exp_v);
    end
    for (int i = 1; i <= 6; i++) begin
      cycle(0, 1, 1, 0, 8'h00);
      vectors++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL redirect_pop R+%0d got %h exp %h", i, obs_v, exp_v);
      end
      if (i >= 3) begin
        vectors++;
        if (o_pc !== 8'h80 + 8'(i - 3)) begin
          errors++;
          $display("FAIL redirect_pop_seq R+%0d got pc=%h exp %h", i, o_pc, 8'h80 + 8'(i - 3));
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    cycle(0, 1, 1, 1, 8'h10);
    cycle(0, 1, 1, 1, 8'h20);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 1, 1, 0, 8'h00);
      vectors++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL back_to_back R+%0d got %h exp %h", i, obs_v, exp_v);
      end
    end
    vectors++;
    if (o_pc !== 8'h21 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_target got pc=%h exp 21", o_pc);
    end
  endtask
  task automatic test_reset_midflight();
    fill(2, "rst_mid");
    cycle(1, 1, 0, 0, 8'h00);
    cycle(0, 0, 0, 0, 8'h00);
    vectors++;
    if (obs_v !== 53'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs got %h exp 0", obs_v);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 1, 0, 8'h00);
      vectors++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL rst_mid_restart c%0d got %h exp %h", i, obs_v, exp_v);
      end
      if (i == 0) begin
        vectors++;
        if (o_req !== 1'b1 || o_addr !== 8'h00) begin
          errors++;
          $display("FAIL rst_mid_first_issue got req=%b addr=%h exp req=1 addr=00", o_req, o_addr);
        end
      end
    end
  endtask
  task automatic test_wrap();
    logic [7:0] want [4];
    logic [7:0] got [$];
    int first = -1;
    want = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    cycle(1, 0, 1, 0, 8'h00);
    en_b  = 1;
    rdy_b = 1;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 0, 8'h00);
      if (ob_valid) begin
        if (first < 0) first = i;
        got.push_back(ob_pc);
        vectors++;
        if (ob_instr !== ~{24'h0, ob_pc}) begin
          errors++;
          $display("FAIL wrap_instr got %h exp %h", ob_instr, ~{24'h0, ob_pc});
        end
      end
    end
    en_b  = 0;
    rdy_b = 0;
    vectors++;
    if (first != 2 || got.size() < 4) begin
      errors++;
      $display("FAIL wrap_latency got first=%0d n=%0d exp first=2 n>=4", first, got.size());
    end else
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (got[i] !== want[i]) begin
          errors++;
          $display("FAIL wrap_seq %0d got %h exp %h", i, got[i], want[i]);
        end
      end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 6, 8'($urandom));
      vectors++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL random c%0d got %h exp %h", i, obs_v, exp_v);
      end
    end
  endtask
  initial begin
    rst_i = 1'b1;
    en_b  = 0;
    rdy_b = 0;
    prev_req = 0;
    prev_req_b = 0;
    prev_addr = 8'h00;
    prev_addr_b = 8'h00;
    m_pc = 8'h00;
    m_ipc = 8'h00;
    m_infl = 0;
    ifa.fetch_en_i = 0; ifa.id_ready_i = 0; ifa.redirect_i = 0; ifa.redirect_pc_i = 8'h00; ifa.imem_rdata_i = 32'h0;
    ifb.fetch_en_i = 0; ifb.id_ready_i = 0; ifb.redirect_i = 0; ifb.redirect_pc_i = 8'h00; ifb.imem_rdata_i = 32'h0;
    @(posedge clk_i);
    #1;
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_back_to_back();
    test_reset_midflight();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
